// File: rtl/merge_sort_ctrl.sv
// Sequencer for the 8-input sorter: collects 8 serial words, pulses sort_rst, captures y, streams results out.
// Latency: last input accepted at T -> first out_valid at T+3+SORT_LAT; MERGE_SORT_CTRL_DESC_EN adds a descending drain.
// Backpressure: in_ready only in FILL (no frame overlap); out_data/out_last hold while out_ready is low.
module merge_sort_ctrl #(
    parameter int W        = 6,
    parameter int SORT_LAT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [8*W-1:0] sort_x,
    output logic           sort_rst,
    input  logic [8*W-1:0] sort_y,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_last,
    output logic           busy,
    output logic [7:0]     frame_cnt
`ifdef MERGE_SORT_CTRL_DESC_EN
    ,
    input  logic           desc
`endif
);

    localparam logic [2:0] S_FILL    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;

    localparam logic [7:0] LAT_M1 = 8'(SORT_LAT - 1);

    logic [2:0]     state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [8*W-1:0] x_q, x_d;
    logic [8*W-1:0] cap_q, cap_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [7:0]     fc_q, fc_d;
    logic [2:0]     slot;

`ifdef MERGE_SORT_CTRL_DESC_EN
    logic desc_q, desc_d;
    // Descending order is just the index mirrored: 7-idx == ~idx for 3 bits.
    assign slot = desc_q ? ~idx_q : idx_q;
`else
    assign slot = idx_q;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        cap_d   = cap_q;
        cnt_d   = cnt_q;
        fc_d    = fc_q;
`ifdef MERGE_SORT_CTRL_DESC_EN
        desc_d  = desc_q;
`endif
        case (state_q)
            S_FILL: begin
                if (in_valid) begin
                    x_d[W*idx_q +: W] = in_data;
`ifdef MERGE_SORT_CTRL_DESC_EN
                    if (idx_q == 3'd0) begin
                        desc_d = desc;
                    end
`endif
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        state_d = S_START;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_START: begin
                cnt_d   = LAT_M1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_CAPTURE: begin
                cap_d   = sort_y;
                idx_d   = 3'd0;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        x_d     = '0;
                        fc_d    = fc_q + 8'd1;
                        state_d = S_FILL;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_FILL;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FILL;
            idx_q   <= 3'd0;
            x_q     <= '0;
            cap_q   <= '0;
            cnt_q   <= 8'd0;
            fc_q    <= 8'd0;
`ifdef MERGE_SORT_CTRL_DESC_EN
            desc_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
            fc_q    <= fc_d;
`ifdef MERGE_SORT_CTRL_DESC_EN
            desc_q  <= desc_d;
`endif
        end
    end

    // The sorter is held in reset whenever the controller is, so an aborted sort never leaks.
    assign sort_rst  = rst | (state_q == S_START);
    assign in_ready  = ~rst & (state_q == S_FILL);
    assign sort_x    = x_q;
    assign busy      = (state_q != S_FILL);
    assign out_valid = (state_q == S_DRAIN);
    assign out_last  = (state_q == S_DRAIN) && (idx_q == 3'd7);
    assign out_data  = (state_q == S_DRAIN) ? cap_q[W*slot +: W] : '0;
    assign frame_cnt = fc_q;

endmodule

// File: tb/tb_merge_sort_ctrl.sv
// Directed and random frames through merge_sort_ctrl with a behavioural sorter that only
// presents sorted data SORT_LAT cycles after sort_rst releases.
module tb_merge_sort_ctrl;

    localparam int W   = 6;
    localparam int LAT = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [8*W-1:0] sort_x;
    logic          sort_rst;
    logic [8*W-1:0] sort_y;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic [7:0]    frame_cnt;
`ifdef MERGE_SORT_CTRL_DESC_EN
    logic          desc;
`endif

    merge_sort_ctrl #(.W(W), .SORT_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sort_x(sort_x), .sort_rst(sort_rst), .sort_y(sort_y),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .frame_cnt(frame_cnt)
`ifdef MERGE_SORT_CTRL_DESC_EN
        , .desc(desc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] din[8];
        int         gap;
        int         rdy_mode;
        logic       dsc;
        logic [5:0] exp[8];
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rst_pulses = 0;
    int exp_fc = 0;
    logic [7:0] lat_cnt = 8'd0;

    function automatic logic [47:0] sort8(input logic [47:0] p);
        logic [5:0] a[8];
        logic [5:0] t;
        logic [47:0] r;
        for (int i = 0; i < 8; i++) a[i] = p[6*i +: 6];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 7 - i; j++)
                if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        for (int i = 0; i < 8; i++) r[6*i +: 6] = a[i];
        return r;
    endfunction

    // Sorter model: garbage until SORT_LAT cycles after reset release, then sorted x.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sort_rst) lat_cnt <= 8'd0;
        else if (lat_cnt != 8'hFF) lat_cnt <= lat_cnt + 8'd1;
        if (sort_rst && !rst) rst_pulses <= rst_pulses + 1;
    end
    always_comb sort_y = (int'(lat_cnt) >= LAT) ? sort8(sort_x) : 48'hA5A5_A5A5_A5A5;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input vec_t v, output int t_last);
        t_last = 0;
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < v.gap; g++) begin
                in_valid = 1'b0;
                in_data  = 6'($urandom_range(0, 63));
                chk("busy_in_gap", int'(busy), 0);
                chk("in_ready_in_gap", int'(in_ready), 1);
                step();
            end
            in_valid = 1'b1;
            in_data  = v.din[i];
`ifdef MERGE_SORT_CTRL_DESC_EN
            desc = (i == 0) ? v.dsc : ~v.dsc;
`endif
            chk("in_ready_fill", int'(in_ready), 1);
            chk("busy_fill", int'(busy), 0);
            t_last = cyc;
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input vec_t v, input int t_last, input int pulse_base);
        int k = 0;
        int d = 0;
        int tmo = 0;
        int t_first = -1;
        logic [47:0] xp;
        logic [3:0] pat = 4'b1001;
        for (int j = 0; j < 8; j++) xp[6*j +: 6] = v.din[j];
        while (k < 8 && tmo < 400) begin
            case (v.rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = pat[3 - (d % 4)];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid) begin
                if (t_first < 0) begin
                    t_first = cyc;
                    chk("first_out_latency", t_first - t_last, LAT + 3);
                    chk("sort_x_held", int'(sort_x == xp), 1);
                end
                chk("out_data", int'(out_data), int'(v.exp[k]));
                chk("out_last", int'(out_last), int'(k == 7));
                chk("in_ready_drain", int'(in_ready), 0);
                chk("busy_drain", int'(busy), 1);
                if (out_ready) k++;
                d++;
            end else begin
                chk("in_ready_pre_drain", int'(in_ready), 0);
            end
            step();
            tmo++;
        end
        out_ready = 1'b0;
        if (k < 8) chk("drain_timeout_words", k, 8);
        exp_fc = (exp_fc + 1) % 256;
        chk("in_ready_after_frame", int'(in_ready), 1);
        chk("busy_after_frame", int'(busy), 0);
        chk("out_valid_after_frame", int'(out_valid), 0);
        chk("sort_x_cleared", int'(sort_x == 48'd0), 1);
        chk("frame_cnt", int'(frame_cnt), exp_fc);
        chk("sort_rst_pulses", rst_pulses - pulse_base, 1);
    endtask

    task automatic run_frame(input vec_t v);
        int t_last;
        int base;
        base = rst_pulses;
        feed(v, t_last);
        drain(v, t_last, base);
    endtask

    vec_t vecs[5];
    int   nvec;
    vec_t rv;
    vec_t rvec;
    int   tl;
    int   bad;
    logic [47:0] pk;
    logic [47:0] sk;

    initial begin
        vecs[0].din = '{6'd51, 6'd4, 6'd45, 6'd2, 6'd1, 6'd8, 6'd5, 6'd7};
        vecs[0].exp = '{6'd1, 6'd2, 6'd4, 6'd5, 6'd7, 6'd8, 6'd45, 6'd51};
        vecs[0].gap = 0; vecs[0].rdy_mode = 0; vecs[0].dsc = 1'b0;
        vecs[1] = vecs[0];
        vecs[1].rdy_mode = 1;
        vecs[2].din = '{6'd0, 6'd63, 6'd63, 6'd0, 6'd32, 6'd32, 6'd1, 6'd62};
        vecs[2].exp = '{6'd0, 6'd0, 6'd1, 6'd32, 6'd32, 6'd62, 6'd63, 6'd63};
        vecs[2].gap = 2; vecs[2].rdy_mode = 0; vecs[2].dsc = 1'b0;
        nvec = 3;
`ifdef MERGE_SORT_CTRL_DESC_EN
        vecs[3] = vecs[0];
        vecs[3].dsc = 1'b1;
        vecs[3].exp = '{6'd51, 6'd45, 6'd8, 6'd7, 6'd5, 6'd4, 6'd2, 6'd1};
        vecs[4] = vecs[0];
        vecs[4].rdy_mode = 1;
        nvec = 5;
        desc = 1'b0;
`endif

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step();
        chk("sort_rst_in_reset", int'(sort_rst), 1);
        step();
        rst = 1'b0;
        step();
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_last", int'(out_last), 0);
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_frame_cnt", int'(frame_cnt), 0);
        chk("reset_sort_x", int'(sort_x == 48'd0), 1);
        chk("reset_sort_rst", int'(sort_rst), 0);

        for (int n = 0; n < nvec; n++) run_frame(vecs[n]);

        // Abort a frame during WAIT; nothing from it may appear on the output.
        feed(vecs[0], tl);
        for (int i = 0; i < 5; i++) step();
        chk("abort_busy_in_wait", int'(busy), 1);
        chk("abort_in_ready_wait", int'(in_ready), 0);
        rst = 1'b1;
        #1;
        chk("abort_sort_rst", int'(sort_rst), 1);
        step();
        rst = 1'b0;
        #1;
        exp_fc = 0;
        chk("abort_frame_cnt", int'(frame_cnt), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_sort_x", int'(sort_x == 48'd0), 1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid || busy) bad++;
            step();
        end
        chk("abort_no_output", bad, 0);
        rv.din = '{6'd8, 6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1};
        rv.exp = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8};
        rv.gap = 0; rv.rdy_mode = 0; rv.dsc = 1'b0;
        run_frame(rv);
        chk("abort_then_frame_cnt", int'(frame_cnt), 1);

        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        exp_fc = 0;
        for (int f = 0; f < 300; f++) begin
            for (int j = 0; j < 8; j++) begin
                rvec.din[j] = 6'($urandom_range(0, 63));
                pk[6*j +: 6] = rvec.din[j];
            end
            rvec.gap = 0;
            rvec.rdy_mode = (f % 3 == 0) ? 2 : 0;
`ifdef MERGE_SORT_CTRL_DESC_EN
            rvec.dsc = 1'($urandom_range(0, 1));
`else
            rvec.dsc = 1'b0;
`endif
            sk = sort8(pk);
            for (int j = 0; j < 8; j++)
                rvec.exp[j] = rvec.dsc ? sk[6*(7-j) +: 6] : sk[6*j +: 6];
            run_frame(rvec);
        end
        chk("frame_cnt_wrap", int'(frame_cnt), 44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
